posit_normalizer_stage: RTL

- Pipelined normalization stage that sits directly upstream of the posit encoder in the PDPU result path.
- Takes the signed fixed-point accumulator sum and its block scale; produces sign, regime value k, exponent and hidden-bit mantissa in exactly the encoder's input format.
- Two register stages with valid/ready flow control and synchronous flush.

---
 rtl/posit_normalizer_stage.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/posit_normalizer_stage.sv
// Two-stage normalizer: fixed-point accumulator sum plus block scale in,
// sign / regime k / exponent / hidden-bit mantissa out for the posit encoder.
package posit_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

module posit_normalizer_stage
  import posit_pkg::*;
#(
  parameter int n           = 16,
  parameter int es          = 1,
  parameter int MANT_WIDTH  = n - es - 3,
  parameter int K_WIDTH     = clog2(n - 1),
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [ACC_WIDTH-1:0]   acc_i,
  input  logic [SCALE_WIDTH-1:0] scale_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   sign_o,
  output logic [K_WIDTH:0]       k_sgn_o,
  output logic [es:0]            exp_o,
  output logic [MANT_WIDTH:0]    mant_norm_o
);

  localparam int P_W = clog2(ACC_WIDTH);
  localparam int E_W =
    ((SCALE_WIDTH > P_W) ? SCALE_WIDTH : P_W) + 2;
  localparam int M_W = MANT_WIDTH + 1;

  localparam logic [P_W-1:0] P_TOP = P_W'(ACC_WIDTH - 1);
  localparam logic signed [E_W-1:0] E_BIAS = E_W'(ACC_WIDTH - 2);
  localparam logic signed [E_W-1:0] K_HI = E_W'(n - 2);
  localparam logic signed [E_W-1:0] K_LO = -E_W'(n - 1);
  localparam logic [M_W-1:0] HIDDEN = {1'b1, {MANT_WIDTH{1'b0}}};

  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic s2_load;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;

  logic                   s1_sign_q, s1_sign_d;
  logic [ACC_WIDTH-1:0]   s1_mag_q, s1_mag_d;
  logic                   s1_zero_q, s1_zero_d;
  logic [P_W-1:0]         s1_p_q, s1_p_d;
  logic [SCALE_WIDTH-1:0] s1_scale_q, s1_scale_d;

  logic             sign_q, sign_d;
  logic [K_WIDTH:0] k_q, k_d;
  logic [es:0]      exp_q, exp_d;
  logic [M_W-1:0]   mant_q, mant_d;

  logic [ACC_WIDTH-1:0] mag_c;
  logic [P_W-1:0]       p_c;

  logic signed [E_W-1:0] scl_x;
  logic signed [E_W-1:0] p_x;
  logic signed [E_W-1:0] e_c;
  logic signed [E_W-1:0] k_c;
  logic [ACC_WIDTH-1:0]  norm_c;
  logic [M_W-1:0]        mant_c;
  logic                  sticky_c;

  logic             sign_n;
  logic [K_WIDTH:0] k_n;
  logic [es:0]      exp_n;
  logic [M_W-1:0]   mant_n;

  // Flush wins over every advance, so it also blocks input acceptance.
  always_comb begin
    s2_adv     = !s2_valid_q | out_ready_i;
    s1_adv     = !s1_valid_q | s2_adv;
    in_ready_o = s1_adv & !flush_i;
    in_fire    = in_valid_i & in_ready_o;
    s2_load    = s2_adv & s1_valid_q & !flush_i;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d = in_valid_i;
      if (s2_adv) s2_valid_d = s1_valid_q;
    end
  end

  always_comb begin
    mag_c = acc_i[ACC_WIDTH-1] ?
            (~acc_i) + ACC_WIDTH'(1) : acc_i;
    p_c = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag_c[i]) p_c = P_W'(i);
    end
  end

  always_comb begin
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_zero_d  = s1_zero_q;
    s1_p_d     = s1_p_q;
    s1_scale_d = s1_scale_q;
    if (in_fire) begin
      s1_sign_d  = acc_i[ACC_WIDTH-1];
      s1_mag_d   = mag_c;
      s1_zero_d  = (acc_i == '0);
      s1_p_d     = p_c;
      s1_scale_d = scale_i;
    end
  end

  // Bits shifted out below the mantissa are jammed into its LSB.
  always_comb begin
    scl_x = {{(E_W-SCALE_WIDTH){s1_scale_q[SCALE_WIDTH-1]}},
             s1_scale_q};
    p_x   = {{(E_W-P_W){1'b0}}, s1_p_q};
    e_c   = scl_x + p_x - E_BIAS;
    k_c   = e_c >>> es;
    norm_c   = s1_mag_q << (P_TOP - s1_p_q);
    sticky_c = |norm_c[ACC_WIDTH-M_W-1:0];
    mant_c   = norm_c[ACC_WIDTH-1 -: M_W];
    mant_c[0] = mant_c[0] | sticky_c;
  end

  always_comb begin
    sign_n = s1_sign_q;
    k_n    = k_c[K_WIDTH:0];
    exp_n  = {1'b0, e_c[es-1:0]};
    mant_n = mant_c;
    unique case (1'b1)
      s1_zero_q: begin
        sign_n = 1'b0;
        k_n    = '0;
        exp_n  = '0;
        mant_n = '0;
      end
      (!s1_zero_q && (k_c > K_HI)): begin
        k_n    = K_HI[K_WIDTH:0];
        exp_n  = '0;
        mant_n = HIDDEN;
      end
      (!s1_zero_q && (k_c < K_LO)): begin
        k_n    = K_LO[K_WIDTH:0];
        exp_n  = '0;
        mant_n = HIDDEN;
      end
      default: begin
        k_n    = k_c[K_WIDTH:0];
        exp_n  = {1'b0, e_c[es-1:0]};
        mant_n = mant_c;
      end
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    k_d    = k_q;
    exp_d  = exp_q;
    mant_d = mant_q;
    if (s2_load) begin
      sign_d = sign_n;
      k_d    = k_n;
      exp_d  = exp_n;
      mant_d = mant_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
      s1_zero_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_scale_q <= '0;
      sign_q     <= 1'b0;
      k_q        <= '0;
      exp_q      <= '0;
      mant_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_mag_q   <= s1_mag_d;
      s1_zero_q  <= s1_zero_d;
      s1_p_q     <= s1_p_d;
      s1_scale_q <= s1_scale_d;
      sign_q     <= sign_d;
      k_q        <= k_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign sign_o      = sign_q;
  assign k_sgn_o     = k_q;
  assign exp_o       = exp_q;
  assign mant_norm_o = mant_q;

endmodule
